// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file write port.
// Optional retire counter is enabled by defining WB_RETIRE_COUNT_EN.
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd_index,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_index,
  input  logic [XLEN-1:0]       lsu_result,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic [XLEN-1:0]       rd,
`ifdef WB_RETIRE_COUNT_EN
  output logic [63:0]           retire_count,
`endif
  output logic                  write_en
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  logic             force_alu_s;
  logic             alu_accept_s;
  logic             lsu_accept_s;

  // Arbitration: LSU has priority unless the ALU has lost STARVE_LIMIT times in a row.
  always_comb begin
    force_alu_s  = (starve_cnt_r == LIMIT_C);
    lsu_ready    = !force_alu_s;
    alu_ready    = force_alu_s || !lsu_valid;
    lsu_accept_s = lsu_valid && lsu_ready;
    alu_accept_s = alu_valid && alu_ready;
  end

  // Next starvation count: saturating increment while the ALU waits, clear otherwise.
  always_comb begin
    starve_cnt_nxt_s = {CNT_W{1'b0}};
    if (alu_valid && !alu_accept_s) begin
      if (starve_cnt_r == LIMIT_C) begin
        starve_cnt_nxt_s = LIMIT_C;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Write-port register; x0 results complete the handshake but never strobe write_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_index <= {ADDR_WIDTH{1'b0}};
      rd       <= {XLEN{1'b0}};
      write_en <= 1'b0;
    end else if (lsu_accept_s) begin
      rd_index <= lsu_rd_index;
      rd       <= lsu_result;
      write_en <= (lsu_rd_index != {ADDR_WIDTH{1'b0}});
    end else if (alu_accept_s) begin
      rd_index <= alu_rd_index;
      rd       <= alu_result;
      write_en <= (alu_rd_index != {ADDR_WIDTH{1'b0}});
    end else begin
      write_en <= 1'b0;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  // Retired-result counter, counting x0 destinations too and wrapping at 2^64.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count <= 64'd0;
    end else if (lsu_accept_s || alu_accept_s) begin
      retire_count <= retire_count + 64'd1;
    end else begin
      retire_count <= retire_count;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by random traffic
// checked against a rule-level reference model.
module tb_writeback_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int SL   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, lsu_valid;
  logic            alu_ready, lsu_ready;
  logic [AW-1:0]   alu_rd_index, lsu_rd_index, rd_index;
  logic [XLEN-1:0] alu_result, lsu_result, rd;
  logic            write_en;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0]     retire_count;
  longint unsigned m_ret;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              m_starve;
  logic            m_we;
  logic [AW-1:0]   m_idx;
  logic [XLEN-1:0] m_rd;
  bit              last_alu_acc, last_lsu_acc;

  writeback_arbiter #(.XLEN(XLEN), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd_index(alu_rd_index), .alu_result(alu_result),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_rd_index(lsu_rd_index), .lsu_result(lsu_result),
    .rd_index(rd_index), .rd(rd),
`ifdef WB_RETIRE_COUNT_EN
    .retire_count(retire_count),
`endif
    .write_en(write_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_we     = 1'b0;
    m_idx    = '0;
    m_rd     = '0;
`ifdef WB_RETIRE_COUNT_EN
    m_ret    = 0;
`endif
  endtask

  // One clock cycle: called just after a negedge with inputs already driven, returns at the next negedge.
  task automatic step();
    bit fa, ar, lr, aacc, lacc;
    fa = (m_starve == SL);
    lr = !fa;
    ar = fa || !lsu_valid;
    #1;
    chk("alu_ready", alu_ready, ar);
    chk("lsu_ready", lsu_ready, lr);
    aacc = alu_valid && ar;
    lacc = lsu_valid && lr;
    @(posedge clk);
    #1;
    if (lacc) begin
      m_idx = lsu_rd_index; m_rd = lsu_result; m_we = (lsu_rd_index != 0);
    end else if (aacc) begin
      m_idx = alu_rd_index; m_rd = alu_result; m_we = (alu_rd_index != 0);
    end else begin
      m_we = 1'b0;
    end
    if (alu_valid && !aacc) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
    else m_starve = 0;
`ifdef WB_RETIRE_COUNT_EN
    if (aacc || lacc) m_ret = m_ret + 1;
    chk("retire_count", retire_count, m_ret);
`endif
    last_alu_acc = aacc;
    last_lsu_acc = lacc;
    chk("write_en", write_en, m_we);
    chk("rd_index", rd_index, m_idx);
    chk("rd", rd, m_rd);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd_index = '0; alu_result = '0;
    lsu_rd_index = '0; lsu_result = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_write_en", write_en, 1'b0);
    chk("rst_rd_index", rd_index, 0);
    chk("rst_rd", rd, 0);
    reset = 1'b1;

    // ALU alone writes x5
    alu_valid = 1'b1; alu_rd_index = 5'd5; alu_result = 32'hDEADBEEF;
    step();
    chk("alu_only_we", write_en, 1'b1);
    alu_valid = 1'b0;
    step();
    chk("alu_only_hold_we", write_en, 1'b0);
    chk("alu_only_hold_rd", rd, 32'hDEADBEEF);

    // Both valid: LSU first, ALU next cycle, no bubble
    alu_valid = 1'b1; alu_rd_index = 5'd4; alu_result = 32'h22;
    lsu_valid = 1'b1; lsu_rd_index = 5'd3; lsu_result = 32'h11;
    step();
    chk("both_first_idx", rd_index, 3);
    lsu_valid = 1'b0;
    step();
    chk("both_second_idx", rd_index, 4);
    chk("both_second_we", write_en, 1'b1);
    alu_valid = 1'b0;
    step();

    // Starvation: ALU waits behind a continuous LSU stream until forced
    alu_valid = 1'b1; alu_rd_index = 5'd9; alu_result = 32'hAA;
    lsu_valid = 1'b1; lsu_rd_index = 5'd10; lsu_result = 32'h100;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 4) chk("starve_alu_wins", rd_index, 9);
      else chk("starve_lsu_wins", rd_index, 10);
      if (last_alu_acc) alu_valid = 1'b0;
      if (last_lsu_acc) lsu_result = lsu_result + 32'd1;
    end
    lsu_valid = 1'b0; alu_valid = 1'b0;
    step();

    // x0 destination: accepted, never written
    alu_valid = 1'b1; alu_rd_index = 5'd0; alu_result = 32'hFFFFFFFF;
    step();
    chk("x0_accepted", last_alu_acc, 1'b1);
    chk("x0_no_write", write_en, 1'b0);
    alu_valid = 1'b0;

    // Reset between the accept edge and the write edge
    lsu_valid = 1'b1; lsu_rd_index = 5'd7; lsu_result = 32'hCAFE;
    step();
    lsu_valid = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_we", write_en, 1'b0);
    chk("midrst_idx", rd_index, 0);
    chk("midrst_rd", rd, 0);
`ifdef WB_RETIRE_COUNT_EN
    chk("midrst_retire", retire_count, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("midrst_no_pulse", write_en, 1'b0);

    // Random traffic; producers hold valid and payload until accepted
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || last_alu_acc) begin
        alu_valid    = ($urandom_range(0, 1) == 1);
        alu_rd_index = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom());
        alu_result   = $urandom();
      end
      if (!lsu_valid || last_lsu_acc) begin
        lsu_valid    = ($urandom_range(0, 9) < 7);
        lsu_rd_index = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom());
        lsu_result   = $urandom();
      end
      last_alu_acc = 1'b0;
      last_lsu_acc = 1'b0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
